// File: rtl/eth_port_arbiter.sv
// eth_port_arbiter: round-robin packet crossbar from per-ingress FWFT queues to egress ports.
// Define ETH_ARB_STATS_EN to add saturating per-egress packet and per-ingress drop counters.
module eth_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter logic [NUM_PORTS*32-1:0] PORT_ADDR = {32'd3, 32'd2, 32'd1, 32'd0},
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS*34-1:0] rd_data,
  input  logic [NUM_PORTS-1:0]    empty,
  input  logic [NUM_PORTS-1:0]    egress_ready,
  output logic [NUM_PORTS-1:0]    rd_en,
  output logic [NUM_PORTS-1:0]    o_valid,
  output logic [NUM_PORTS*32-1:0] o_data,
  output logic [NUM_PORTS-1:0]    o_start,
  output logic [NUM_PORTS-1:0]    o_end,
  output logic [NUM_PORTS-1:0]    o_port_busy,
  output logic [NUM_PORTS-1:0]    drop_pulse
`ifdef ETH_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt,
  output logic [NUM_PORTS*CNT_W-1:0] drop_cnt
`endif
);
  localparam int IW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} st_e;
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || CNT_W < 1) begin : g_bad_params
    $error("eth_port_arbiter: unsupported NUM_PORTS or CNT_W");
  end
  st_e st_q [NUM_PORTS];
  st_e st_d [NUM_PORTS];
  logic [IW-1:0] dest_q [NUM_PORTS];
  logic [IW-1:0] dest_d [NUM_PORTS];
  logic [IW-1:0] owner_q [NUM_PORTS];
  logic [IW-1:0] owner_d [NUM_PORTS];
  logic [IW-1:0] rr_q [NUM_PORTS];
  logic [IW-1:0] rr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] own_v_q, own_v_d, grant, drop_d;
  logic [NUM_PORTS-1:0] o_valid_d, o_start_d, o_end_d;
  logic [NUM_PORTS*32-1:0] o_data_d;
  int src, idx, win;
  logic found, hit, sop, eop_pop;
  logic [IW-1:0] mi;

  always_comb begin
    rd_en = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rd_en[i] = !rst && !empty[i] && (st_q[i] == DROP || (st_q[i] == IDLE && !rd_data[i*34+32]) ||
                 (st_q[i] == XFER && egress_ready[dest_q[i]]));
  end

  // Owned egresses forward the owner's pop; unowned egresses pick the next REQ ingress from rr_q.
  always_comb begin
    own_v_d = own_v_q;
    owner_d = owner_q;
    rr_d = rr_q;
    grant = '0;
    o_valid_d = '0;
    o_start_d = '0;
    o_end_d = '0;
    o_data_d = '0;
    src = 0;
    idx = 0;
    win = 0;
    found = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      win = 0;
      found = 1'b0;
      if (own_v_q[p]) begin
        src = int'(owner_q[p]);
        o_valid_d[p] = rd_en[src];
        o_start_d[p] = rd_en[src] && rd_data[src*34+32];
        o_end_d[p] = rd_en[src] && rd_data[src*34+33];
        o_data_d[p*32 +: 32] = rd_en[src] ? rd_data[src*34 +: 32] : 32'd0;
        own_v_d[p] = !o_end_d[p];
      end else begin
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
          idx = (int'(rr_q[p]) + k) % NUM_PORTS;
          if (st_q[idx] == REQ && dest_q[idx] == IW'(p)) begin
            win = idx;
            found = 1'b1;
          end
        end
        own_v_d[p] = found;
        owner_d[p] = found ? IW'(win) : owner_q[p];
        rr_d[p] = found ? IW'((win + 1) % NUM_PORTS) : rr_q[p];
        if (found) grant[win] = 1'b1;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    dest_d = dest_q;
    drop_d = '0;
    hit = 1'b0;
    mi = '0;
    sop = 1'b0;
    eop_pop = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit = 1'b0;
      mi = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--)
        if (rd_data[i*34 +: 32] == PORT_ADDR[p*32 +: 32]) begin
          hit = 1'b1;
          mi = IW'(p);
        end
      sop = !empty[i] && rd_data[i*34+32];
      eop_pop = rd_en[i] && rd_data[i*34+33];
      case (st_q[i])
        IDLE: begin
          st_d[i] = sop ? (hit ? REQ : DROP) : IDLE;
          dest_d[i] = (sop && hit) ? mi : dest_q[i];
          drop_d[i] = rd_en[i];
        end
        REQ: st_d[i] = grant[i] ? XFER : REQ;
        XFER: st_d[i] = eop_pop ? IDLE : XFER;
        default: begin
          st_d[i] = eop_pop ? IDLE : DROP;
          drop_d[i] = eop_pop;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '{default: IDLE};
      dest_q <= '{default: '0};
      owner_q <= '{default: '0};
      rr_q <= '{default: '0};
      own_v_q <= '0;
      o_valid <= '0;
      o_data <= '0;
      o_start <= '0;
      o_end <= '0;
      drop_pulse <= '0;
    end else begin
      st_q <= st_d;
      dest_q <= dest_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      own_v_q <= own_v_d;
      o_valid <= o_valid_d;
      o_data <= o_data_d;
      o_start <= o_start_d;
      o_end <= o_end_d;
      drop_pulse <= drop_d;
    end
  end

  assign o_port_busy = own_v_q;

`ifdef ETH_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (o_end_d[p] && !(&pkt_cnt[p*CNT_W +: CNT_W]))
          pkt_cnt[p*CNT_W +: CNT_W] <= pkt_cnt[p*CNT_W +: CNT_W] + 1'b1;
        if (drop_d[p] && !(&drop_cnt[p*CNT_W +: CNT_W]))
          drop_cnt[p*CNT_W +: CNT_W] <= drop_cnt[p*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_eth_port_arbiter.sv
// tb_eth_port_arbiter: directed bench with queue-fed ingresses, per-egress packet scoreboard
// and a transaction-level round-robin model; stats checks run when ETH_ARB_STATS_EN is defined.
module tb_eth_port_arbiter;
  localparam int N = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*34-1:0] rd_data;
  logic [N-1:0] empty, egress_ready, rd_en, o_valid, o_start, o_end, o_port_busy, drop_pulse;
  logic [N*32-1:0] o_data;
`ifdef ETH_ARB_STATS_EN
  logic [N*CW-1:0] pkt_cnt, drop_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [33:0] inq [N][$];
  logic [33:0] exq [N][$];
  int pops [N];
  int drops [N];
  int exp_drop [N];
  int vcnt [N];
  int first_v [N];
  int last_v [N];
  int rr_m [N];
  logic [N-1:0] prev_v = '0;
  logic [N-1:0] pe;
  logic [33:0] got, want;
  int k, w;

  eth_port_arbiter #(.NUM_PORTS(N), .PORT_ADDR({32'd3, 32'd2, 32'd1, 32'd0}), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rd_data(rd_data), .empty(empty), .egress_ready(egress_ready),
    .rd_en(rd_en), .o_valid(o_valid), .o_data(o_data), .o_start(o_start), .o_end(o_end),
    .o_port_busy(o_port_busy), .drop_pulse(drop_pulse)
`ifdef ETH_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: address a routes to egress a when a < N, otherwise it is dropped.
  function automatic int route(logic [31:0] a);
    return (a < N) ? int'(a) : -1;
  endfunction

  function automatic int rr_pick(int p, logic [N-1:0] m);
    int c;
    for (int j = 0; j < N; j++) begin
      c = (rr_m[p] + j) % N;
      if (m[c]) begin
        rr_m[p] = (c + 1) % N;
        return c;
      end
    end
    return -1;
  endfunction

  function automatic logic [33:0] wd(int i, logic [31:0] a, int n, int tag, int j);
    return (j == 0) ? {n == 1, 1'b1, a} : {j == n - 1, 1'b0, 8'(i), 8'(tag), 16'(j)};
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (inq[i].size() != 0 || exq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      empty[i] = inq[i].size() == 0;
      rd_data[i*34 +: 34] = empty[i] ? 34'd0 : inq[i][0];
    end
  endtask

  task automatic chk(string nm, logic [63:0] g, logic [63:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, g, x);
    end
  endtask

  task automatic load(int i, logic [31:0] a, int n, int tag);
    for (int j = 0; j < n; j++) inq[i].push_back(wd(i, a, n, tag, j));
    if (route(a) < 0) exp_drop[i]++;
    refresh();
  endtask

  task automatic expect_pkt(int i, logic [31:0] a, int n, int tag);
    for (int j = 0; j < n; j++) exq[route(a)].push_back(wd(i, a, n, tag, j));
  endtask

  task automatic send(int i, logic [31:0] a, int n, int tag);
    load(i, a, n, tag);
    if (route(a) >= 0) begin
      void'(rr_pick(route(a), N'(1) << i));
      expect_pkt(i, a, n, tag);
    end
  endtask

  task automatic stray(int i, logic [31:0] d);
    inq[i].push_back({2'b00, d});
    exp_drop[i]++;
    refresh();
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      pops[i] = 0;
      vcnt[i] = 0;
      first_v[i] = -1;
      last_v[i] = -1;
    end
  endtask

  task automatic wait_valid(int p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid[p] && n < 50);
    chk($sformatf("wait_valid_e%0d", p), o_valid[p], 1);
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while (n < lim && pending()) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_done", pending(), 0);
  endtask

  always @(posedge clk) begin
    pe = rd_en & ~empty;
    checks++;
    if ((rd_en & (empty | {N{rst}})) != '0) begin
      errors++;
      $display("FAIL rd_en_illegal got=%b empty=%b rst=%b want no pop from empty queue or in reset", rd_en, empty, rst);
    end
    #1;
    for (int i = 0; i < N; i++)
      if (pe[i]) begin
        void'(inq[i].pop_front());
        pops[i]++;
      end
    refresh();
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int p = 0; p < N; p++) begin
        if (o_valid[p]) begin
          got = {o_end[p], o_start[p], o_data[p*32 +: 32]};
          checks++;
          if (exq[p].size() == 0) begin
            errors++;
            $display("FAIL egress%0d_word got=%h want=none", p, got);
          end else begin
            want = exq[p].pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL egress%0d_word got=%h want=%h", p, got, want);
            end
          end
          if (o_start[p]) begin
            checks++;
            if (prev_v[p]) begin
              errors++;
              $display("FAIL egress%0d_gap got=no idle cycle before start want=idle cycle", p);
            end
          end
          vcnt[p]++;
          if (first_v[p] < 0) first_v[p] = cyc;
          last_v[p] = cyc;
        end
        if (drop_pulse[p]) drops[p]++;
      end
    end
    prev_v = rst ? '0 : o_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rr_m[i] = 0;
      drops[i] = 0;
      exp_drop[i] = 0;
    end
    clear();
    egress_ready = '1;
    refresh();
    stray(3, 32'h5A5A_0003);
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_port_busy, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data", o_data, 0);
    rst = 1'b0;
    drain(50);
    chk("stray_after_rst_drop", drops[3], 1);
    // single packet, ingress 0 -> egress 2
    clear();
    send(0, 32'd2, 3, 1);
    wait_valid(2, k);
    chk("t1_latency", k, 3);
    chk("t1_busy", o_port_busy[2], 1);
    drain(50);
    chk("t1_pops", pops[0], 3);
    chk("t1_words", vcnt[2], 3);
    chk("t1_span", last_v[2] - first_v[2], 2);
    // contention on egress 0: 1 wins at rr=0, then 3 ahead of 1's second packet
    clear();
    load(1, 32'd0, 3, 1);
    load(1, 32'd0, 2, 2);
    load(3, 32'd0, 4, 3);
    w = rr_pick(0, 4'b1010);
    chk("t2_model_first", w, 1);
    expect_pkt(1, 32'd0, 3, 1);
    w = rr_pick(0, 4'b1010);
    chk("t2_model_second", w, 3);
    expect_pkt(3, 32'd0, 4, 3);
    w = rr_pick(0, 4'b0010);
    chk("t2_model_third", w, 1);
    expect_pkt(1, 32'd0, 2, 2);
    drain(100);
    chk("t2_words", vcnt[0], 9);
    chk("t2_pops1", pops[1], 5);
    chk("t2_pops3", pops[3], 4);
    // backpressure on egress 2 for 4 cycles
    clear();
    send(0, 32'd2, 5, 4);
    wait_valid(2, k);
    egress_ready[2] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t3_stall", {o_valid[2], rd_en[0], o_port_busy[2]}, 3'b001);
    end
    egress_ready[2] = 1'b1;
    drain(60);
    chk("t3_words", vcnt[2], 5);
    chk("t3_span", last_v[2] - first_v[2], 8);
    // unknown destination and stray word
    clear();
    load(1, 32'hDEAD, 2, 7);
    stray(2, 32'h1234);
    drain(50);
    chk("t4_pops1", pops[1], 2);
    chk("t4_pops2", pops[2], 1);
    chk("t4_drop1", drops[1], exp_drop[1]);
    chk("t4_drop2", drops[2], exp_drop[2]);
    chk("t4_quiet", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], 0);
    // reset in the middle of a transfer
    clear();
    send(2, 32'd3, 8, 5);
    wait_valid(3, k);
    rst = 1'b1;
    #1;
    chk("t5_valid", o_valid, 0);
    chk("t5_busy", o_port_busy, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_data", o_data, 0);
    inq[2].delete();
    exq[3].delete();
    refresh();
    for (int i = 0; i < N; i++) rr_m[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear();
    send(2, 32'd3, 3, 6);
    wait_valid(3, k);
    chk("t5_latency", k, 3);
    drain(50);
    chk("t5_words", vcnt[3], 3);
`ifdef ETH_ARB_STATS_EN
    clear();
    for (int j = 0; j < 5; j++) send(2, 32'd1, 2, 10 + j);
    load(0, 32'hDEAD, 2, 20);
    load(0, 32'hBEEF, 1, 21);
    drain(200);
    chk("t6_pkt1", pkt_cnt[1*CW +: CW], 5);
    chk("t6_pkt3", pkt_cnt[3*CW +: CW], 1);
    chk("t6_drop0", drop_cnt[0 +: CW], 2);
    for (int j = 0; j < 6; j++) send(2, 32'd1, 1, 30 + j);
    drain(200);
    chk("t6_pkt1_sat", pkt_cnt[1*CW +: CW], 7);
`endif
    for (int i = 0; i < N; i++) chk($sformatf("final_drops_i%0d", i), drops[i], exp_drop[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_port_arbiter.md
Name: eth_port_arbiter

Overview:
Packet-level crossbar scheduler between the per-ingress TX queues and the egress ports of the switch. It reads each queue's head word, decodes the destination from the first packet word, and arbitrates round-robin among the ingresses that contend for the same egress. It holds each grant until the end-of-packet word is transferred, then forwards the words registered onto the egress port.

Parameters:
NUM_PORTS, 4, number of ingress queues and egress ports (2..8)
PORT_ADDR, {32'd3,32'd2,32'd1,32'd0}, packed NUM_PORTS*32 vector; slice p is the 32-bit address of egress port p
CNT_W, 16, width of statistics counters (ETH_ARB_STATS_EN only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rd_data  in  NUM_PORTS*34  per-ingress head word {end[33], start[32], data[31:0]}, first-word-fall-through
empty  in  NUM_PORTS  per-ingress queue empty flag
egress_ready  in  NUM_PORTS  egress p can accept a word this cycle
rd_en  out  NUM_PORTS  per-ingress pop strobe (combinational)
o_valid  out  NUM_PORTS  egress word valid (registered)
o_data  out  NUM_PORTS*32  egress data
o_start  out  NUM_PORTS  egress start-of-packet
o_end  out  NUM_PORTS  egress end-of-packet
o_port_busy  out  NUM_PORTS  egress p currently owned by an ingress
drop_pulse  out  NUM_PORTS  one-cycle pulse per ingress when a packet or stray word is discarded

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, all ingress FSMs IDLE, all egress owners cleared, RR pointers 0. Reset mid-packet abandons the packet. No pop occurs while rst is high.
- Per-ingress FSM: IDLE, REQ, XFER, DROP.
- IDLE with ~empty and start=1: compare data against every PORT_ADDR slice, register the matching index as dest, go to REQ. No pop occurs in this cycle.
- IDLE with ~empty, start=1 and no address match: go to DROP.
- IDLE with ~empty and start=0 (stray word): pop it, pulse drop_pulse, stay IDLE.
- DROP: rd_en = ~empty. Stay in DROP until the end word is popped, then pulse drop_pulse on the cycle after the pop and return to IDLE.
- Per-egress arbiter: evaluated each cycle only while egress p is unowned. Candidates are ingresses in REQ with dest=p. Search starts at rr_ptr[p] and wraps modulo NUM_PORTS. The winner is registered as owner[p], its FSM goes to XFER, and rr_ptr[p] is set to winner+1 mod NUM_PORTS. Losers stay in REQ.
- Ingress dest equal to its own index is permitted; no filtering is applied.
- XFER: rd_en = ~empty & egress_ready[dest]. Each popped word appears on o_valid/o_data/o_start/o_end of egress dest on the next cycle.
- In XFER, empty or ~egress_ready drops o_valid the next cycle and keeps the grant.
- Popping the end word clears owner[dest] at that edge and returns the FSM to IDLE. A single word with start=end=1 is a complete packet.
- o_port_busy[p] = owner valid, registered.
- Latency: head word with start visible in cycle t → REQ at t+1 → grant at the edge ending t+1 → first pop at t+2 → o_valid at t+3.
- At least one idle cycle between back-to-back packets on the same egress.
- Each ingress has at most one egress grant, and each egress has at most one owner.
- Grants are packet-atomic. Words of two packets never interleave on one egress.

Optional Feature:
ETH_ARB_STATS_EN — when defined, adds outputs pkt_cnt (NUM_PORTS*CNT_W, per-egress count of end words forwarded) and drop_cnt (NUM_PORTS*CNT_W, per-ingress count of drop_pulse). Both counters saturate at all-ones and reset to 0. When undefined, these ports and their counter logic are absent and all other behaviour is identical.

Test Plan:
1. Ingress 0 has a 3-word packet with dest 32'd2 (start word, then 2 data words); egress_ready all 1 → o_valid[2] high from t+3 for 3 cycles with start, data, end; o_port_busy[2]=1 during transfer; rd_en[0] pulses 3 times.
2. Ingresses 1 and 3 both target egress 0 in the same cycle with rr_ptr=0 → ingress 1 granted first. Ingress 3 is granted after ingress 1's end word, with ≥1 idle cycle and no interleaving. The next contention grants 3 ahead of 1.
3. egress_ready[2] is deasserted for 4 cycles mid-packet → rd_en pauses and o_valid[2]=0 for 4 cycles. Grant is held, and the packet completes intact.
4. Head word with dest 32'hDEAD and a 2-word packet → both words popped, drop_pulse one cycle, no egress activity. A stray start=0 word in IDLE → popped and drop_pulse raised.
5. rst asserted while ingress 2 is in XFER → outputs 0 immediately. After release, a new packet is granted normally.
6. With ETH_ARB_STATS_EN defined, forward 5 packets to egress 1 and drop 2 at ingress 0 → pkt_cnt[1]=5, drop_cnt[0]=2. Force 2^CNT_W+3 packets → pkt_cnt saturates at all-ones.
